// File: rtl/decode_stage.sv
// IF/ID stage: two-entry skid buffer, flush bubble window and field/format decode; DECODE_ILLEGAL_EN adds the illegal check.
// Latency 1 cycle; in_ready drops the cycle after the skid fills or while a post-flush bubble is counting.
module decode_stage #(
  parameter int PC_W          = 32,
  parameter int BUBBLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rr1,
  output logic [4:0]      rr2,
  output logic [4:0]      rw,
  output logic [24:0]     imm,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [5:0]      fmt,
  output logic            illegal
);

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } entry_t;

  localparam logic [3:0] BUBBLE_INIT = 4'(BUBBLE_CYCLES);

  entry_t     m_q, m_d, s_q, s_d;
  logic       m_valid_q, m_valid_d;
  logic       s_valid_q, s_valid_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic       accept, consume;
  entry_t     in_ent;

  assign in_ent   = '{inst: in_inst, pc: in_pc};
  assign in_ready = !s_valid_q && (bcnt_q == 4'd0) && !flush;
  assign accept   = in_valid && in_ready;
  assign consume  = m_valid_q && out_ready;

  always_comb begin
    m_d       = m_q;
    m_valid_d = m_valid_q;
    s_d       = s_q;
    s_valid_d = s_valid_q;
    bcnt_d    = (bcnt_q != 4'd0) ? bcnt_q - 4'd1 : 4'd0;
    if (flush) begin
      m_d       = '0;
      m_valid_d = 1'b0;
      s_d       = '0;
      s_valid_d = 1'b0;
      bcnt_d    = BUBBLE_INIT;
    end else if (consume) begin
      // A full skid blocks in_ready, so accept and skid drain never coincide.
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_d       = '0;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_d       = in_ent;
        m_valid_d = 1'b1;
      end else begin
        m_d       = '0;
        m_valid_d = 1'b0;
      end
    end else if (!m_valid_q) begin
      if (accept) begin
        m_d       = in_ent;
        m_valid_d = 1'b1;
      end
    end else if (accept) begin
      s_d       = in_ent;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      m_valid_q <= 1'b0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
      bcnt_q    <= 4'd0;
    end else begin
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
      s_q       <= s_d;
      s_valid_q <= s_valid_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_inst  = m_q.inst;
  assign out_pc    = m_q.pc;
  assign rr1       = m_q.inst[19:15];
  assign rr2       = m_q.inst[24:20];
  assign rw        = m_q.inst[11:7];
  assign imm       = m_q.inst[31:7];
  assign opcode    = m_q.inst[6:0];
  assign funct3    = m_q.inst[14:12];
  assign funct7    = m_q.inst[31:25];

  // fmt bit order is {J,U,B,S,I,R}.
  always_comb begin
    fmt = 6'b000000;
    case (opcode)
      7'b0110011:                                   fmt = 6'b000001;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = 6'b000010;
      7'b0100011:                                   fmt = 6'b000100;
      7'b1100011:                                   fmt = 6'b001000;
      7'b0110111, 7'b0010111:                       fmt = 6'b010000;
      7'b1101111:                                   fmt = 6'b100000;
      default:                                      fmt = 6'b000000;
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  logic shift_bad;
  assign shift_bad = (opcode == 7'b0010011) && (funct3[1:0] == 2'b01) &&
                     (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
  assign illegal   = m_valid_q && ((opcode[1:0] != 2'b11) || (fmt == 6'b000000) || shift_bad);
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage with BUBBLE_CYCLES = 3.
module tb_decode_stage;

  localparam int PC_W = 32;
  localparam int BUB  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_inst = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      rr1, rr2, rw;
  logic [24:0]     imm;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [5:0]      fmt;
  logic            illegal;

  decode_stage #(.PC_W(PC_W), .BUBBLE_CYCLES(BUB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .rr1(rr1), .rr2(rr2), .rw(rw), .imm(imm),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .fmt(fmt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } ent_t;

  ent_t sb[$];
  int   mbcnt  = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_fmt(input logic [6:0] op);
    logic [5:0] f;
    f = 6'd0;
    if (op == 7'h33) f[0] = 1'b1;
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) f[1] = 1'b1;
    if (op == 7'h23) f[2] = 1'b1;
    if (op == 7'h63) f[3] = 1'b1;
    if (op == 7'h37 || op == 7'h17) f[4] = 1'b1;
    if (op == 7'h6F) f[5] = 1'b1;
    return f;
  endfunction

  function automatic logic exp_illegal(input logic [31:0] i, input logic v);
`ifdef DECODE_ILLEGAL_EN
    logic bad;
    bad = (i[1:0] != 2'b11) || (exp_fmt(i[6:0]) == 6'd0) ||
          (i[6:0] == 7'h13 && i[13:12] == 2'b01 && i[31:25] != 7'h00 && i[31:25] != 7'h20);
    return v && bad;
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_outputs();
    ent_t e;
    logic v;
    v = (sb.size() > 0);
    e = v ? sb[0] : '0;
    check("in_ready",  in_ready,  (sb.size() < 2) && (mbcnt == 0) && !flush);
    check("out_valid", out_valid, v);
    check("out_inst",  out_inst,  e.inst);
    check("out_pc",    out_pc,    e.pc);
    check("rr1",       rr1,       e.inst[19:15]);
    check("rr2",       rr2,       e.inst[24:20]);
    check("rw",        rw,        e.inst[11:7]);
    check("imm",       imm,       e.inst[31:7]);
    check("opcode",    opcode,    e.inst[6:0]);
    check("funct3",    funct3,    e.inst[14:12]);
    check("funct7",    funct7,    e.inst[31:25]);
    check("fmt",       fmt,       exp_fmt(e.inst[6:0]));
    check("illegal",   illegal,   exp_illegal(e.inst, v));
  endtask

  // One clock: check at negedge, then advance the model across the posedge.
  task automatic cycle();
    logic acc, cons;
    @(negedge clk);
    compare_outputs();
    acc  = in_valid && (sb.size() < 2) && (mbcnt == 0) && !flush;
    cons = (sb.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
      mbcnt = BUB;
    end else begin
      if (mbcnt > 0) mbcnt--;
      if (cons) void'(sb.pop_front());
      if (acc) sb.push_back('{inst: in_inst, pc: in_pc});
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic ordy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = $urandom;
    out_ready = ordy;
    flush     = fl;
    cycle();
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sb.size() > 0; k++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [31:0] tbl [8] = '{32'h00500093, 32'h002081B3, 32'h00312023, 32'h00000463,
                           32'h0000007F, 32'h02109093, 32'h12345037, 32'h0080006F};

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_inst",  out_inst,  32'h0);
    check("rst_fmt",       fmt,       6'h0);
    check("rst_illegal",   illegal,   1'b0);
    rst = 1'b0;

    // First instruction, then a back-to-back R/S/B stream
    drive(1'b1, 32'h00500093, 1'b1, 1'b0);
    drive(1'b1, 32'h002081B3, 1'b1, 1'b0);
    drive(1'b1, 32'h00312023, 1'b1, 1'b0);
    drive(1'b1, 32'h00000463, 1'b1, 1'b0);
    drain();

    // Execute stall: skid fills, in_ready drops, then in-order drain
    for (int k = 0; k < 4; k++) drive(1'b1, 32'h00100013 + (k << 7), 1'b0, 1'b0);
    drain();

    // Flush with both entries full, then a re-flush inside the window
    drive(1'b1, 32'h00A00113, 1'b0, 1'b0);
    drive(1'b1, 32'h00B00193, 1'b0, 1'b0);
    drive(1'b1, 32'h00C00213, 1'b0, 1'b1);
    drive(1'b1, 32'h00D00293, 1'b1, 1'b0);
    drive(1'b1, 32'h00D00293, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) drive(1'b1, 32'h00E00313 + (k << 20), 1'b1, 1'b0);
    drain();

    // Unrecognised opcode and a bad shift-immediate funct7
    drive(1'b1, 32'h0000007F, 1'b1, 1'b0);
    drive(1'b1, 32'h02109093, 1'b1, 1'b0);
    drive(1'b1, 32'h40105093, 1'b1, 1'b0);
    drain();

    // Random traffic with occasional flushes
    for (int k = 0; k < 300; k++) begin
      logic [31:0] ins;
      ins = ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 7)] : $urandom;
      drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end
    flush = 1'b0;
    for (int k = 0; k < 6; k++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    drain();

    // Reset asserted mid-stall with both entries full
    drive(1'b1, 32'h00F00393, 1'b0, 1'b0);
    drive(1'b1, 32'h01000413, 1'b0, 1'b0);
    drive(1'b1, 32'h01100493, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_out_inst",  out_inst,  32'h0);
    sb.delete();
    mbcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h00500093, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
